hazard3_shift_pipe: RTL
=======================

Name: hazard3_shift_pipe

Overview:
- Two-stage pipelined shift unit with a valid/ready handshake on both sides.
- Decodes a compact shift opcode into direction/arith/rotate controls and captures operands in stage 1.
- Drives a combinational log-type barrel shifter from stage-1 registers; registers the result in stage 2.
- Sits between the ALU issue logic (upstream) and the writeback arbiter (downstream); used for multi-cycle or timing-relaxed shift paths.

Parameters:
- W_DATA, 32, datapath width; power of two, ≥8.
- W_SHAMT, $clog2(W_DATA), shift-amount width; derived, not overridden.
- EXTENSION_ZBB, 1, enables ROL/ROR; when 0, rotate ops are illegal.
- W_TAG, 5, width of the sideband tag (destination register index) carried alongside each op.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all in-flight ops.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  unit can accept op this cycle.
- in_op  input  3  0=SLL, 1=SRL, 2=SRA, 3=ROL, 4=ROR, 5..7 reserved.
- in_rs1  input  W_DATA  value to shift.
- in_rs2  input  W_DATA  shift amount source; only bits [W_SHAMT-1:0] used.
- in_tag  input  W_TAG  sideband, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  W_DATA  shifted value.
- out_tag  output  W_TAG  tag of the result.
- out_illegal  output  1  op was reserved, or a rotate with EXTENSION_ZBB=0.

Behaviour:
- Reset, async on rst_n low: s1_valid=0, s2_valid=0; out_valid=0, out_result=0, out_tag=0, out_illegal=0; stage-1 operand regs cleared to 0. in_ready=1 after reset (flush low).
- Handshake: a transfer occurs when valid && ready. out_valid must not drop and out_result/out_tag/out_illegal must not change while out_valid && !out_ready.
- in_ready = !flush && (!s1_valid || s2_adv), where s2_adv = !s2_valid || out_ready. Combinational path from out_ready to in_ready is allowed.
- Stage 1 capture on input transfer:
  - rs1; shamt = in_rs2[W_SHAMT-1:0]; tag.
  - right_nleft = op ∈ {SRL, SRA, ROR}.
  - arith = (op == SRA).
  - rotate = op ∈ {ROL, ROR} && EXTENSION_ZBB.
  - illegal = op ≥ 5 || (op ∈ {ROL, ROR} && !EXTENSION_ZBB).
- Stage 1 → stage 2 moves when s1_valid && s2_adv. Stage 2 loads the shifter output, or 0 if illegal, plus tag and illegal flag. s1_valid clears unless a new op enters in the same cycle.
- Latency: op accepted in cycle N appears on out_valid in cycle N+2.
- Throughput: one op per cycle when out_ready stays high. Capacity is 2 ops. With out_ready low, the unit fills after 2 accepts and in_ready goes low.
- Simultaneous input and output transfer in the same cycle is legal and keeps the pipe full.
- Arithmetic:
  - shamt 0 returns rs1 unchanged for every op.
  - SRA sign-fills from rs1[W_DATA-1].
  - ROL by k equals ROR by (W_DATA−k) mod W_DATA.
  - No shift amount ≥ W_DATA is possible, because shamt is truncated.
- flush: next edge clears s1_valid and s2_valid. in_ready is low while flush is high, so any op presented that cycle is not accepted. out_valid is killed even if out_ready was high in the flush cycle; the downstream side must ignore the output during flush.
- Reset asserted mid-operation discards all ops immediately, with no output.

Decomposition:
- Shared package/header: opcode constants (SHIFT_OP_SLL..SHIFT_OP_ROR), W_SHAMT derivation, and the EXTENSION_ZBB flag from the common config include.
- Exactly one sub-module: hazard3_shift_barrel. It is instantiated combinationally between the stage-1 and stage-2 registers, driven by din, shamt, right_nleft, rotate and arith.
- Handshake and decode logic stay in this module.

Test Plan:
- Reset then SLL: rs1=0x0000_0001, rs2=0x24 (shamt=4), tag=7 → two cycles later out_result=0x0000_0010, out_tag=7, out_illegal=0.
- SRA vs SRL: rs1=0x8000_0000, shamt=31.
  - SRA → 0xFFFF_FFFF.
  - SRL → 0x0000_0001.
  - Issued back-to-back with out_ready=1 → results on consecutive cycles.
- Rotates: rs1=0x1234_5678, shamt=8.
  - ROR → 0x7812_3456.
  - ROL → 0x3456_7812.
  - With EXTENSION_ZBB=0 → out_result=0, out_illegal=1.
- Backpressure: hold out_ready=0 and offer 3 ops → in_ready low after 2 accepts and out_result stable. Raise out_ready → ops drain in order with correct tags.
- Flush with pipe full and in_valid=1 → next cycle out_valid=0 and in_ready=1. The flush-cycle input never appears at the output.
- Reserved op=6 with rs1=0xDEAD_BEEF → out_result=0, out_illegal=1, tag preserved. Async rst_n pulse mid-stream → out_valid=0 immediately.

Source files
------------

// File: rtl/hazard3_shift_pipe_pkg.sv
// Shared opcode constants, decode helper and width derivation for the shift pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard3_shift_pipe_pkg;

  localparam int W_DATA_DFLT        = 32;
  localparam bit EXTENSION_ZBB_DFLT = 1'b1;
  localparam int W_TAG_DFLT         = 5;

  typedef enum logic [2:0] {
    SHIFT_OP_SLL = 3'd0,
    SHIFT_OP_SRL = 3'd1,
    SHIFT_OP_SRA = 3'd2,
    SHIFT_OP_ROL = 3'd3,
    SHIFT_OP_ROR = 3'd4
  } shift_op_e;

  typedef struct packed {
    logic right_nleft;
    logic arith;
    logic rotate;
    logic illegal;
  } shift_ctrl_t;

  // Shift amount width follows the datapath width; never overridden separately.
  function automatic int shamt_width(input int w_data);
    return $clog2(w_data);
  endfunction

  // Rotates only decode as legal when the bit-manip extension is present.
  function automatic shift_ctrl_t shift_decode(input logic [2:0] op, input logic zbb);
    shift_ctrl_t c;
    logic        is_rot;
    is_rot        = (op == SHIFT_OP_ROL) || (op == SHIFT_OP_ROR);
    c.right_nleft = (op == SHIFT_OP_SRL) || (op == SHIFT_OP_SRA) || (op == SHIFT_OP_ROR);
    c.arith       = (op == SHIFT_OP_SRA);
    c.rotate      = is_rot && zbb;
    c.illegal     = (op > SHIFT_OP_ROR) || (is_rot && !zbb);
    return c;
  endfunction

endpackage

// File: rtl/hazard3_shift_barrel.sv
// Log-depth barrel shifter: right shift / rotate core, left ops via bit reversal.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module hazard3_shift_barrel
  import hazard3_shift_pipe_pkg::*;
#(
  parameter int W_DATA  = W_DATA_DFLT,
  parameter int W_SHAMT = shamt_width(W_DATA)
) (
  input  logic [W_DATA-1:0]  din,
  input  logic [W_SHAMT-1:0] shamt,
  input  logic               right_nleft,
  input  logic               rotate,
  input  logic               arith,
  output logic [W_DATA-1:0]  dout
);

  logic [W_DATA-1:0]             din_rev;
  logic [W_DATA-1:0]             res_rev;
  logic [W_SHAMT:0][W_DATA-1:0]  stg;
  logic                          fill;

  // Left shifts reuse the right-shift network on the bit-reversed operand.
  for (genvar i = 0; i < W_DATA; i++) begin : g_rev
    assign din_rev[i] = din[W_DATA-1-i];
    assign res_rev[i] = stg[W_SHAMT][W_DATA-1-i];
  end

  // Sign fill only applies to arithmetic right shifts.
  assign fill   = arith & right_nleft & din[W_DATA-1];
  assign stg[0] = right_nleft ? din : din_rev;

  // Stage s shifts right by 2**s; vacated bits take the wrapped bits or the fill.
  for (genvar s = 0; s < W_SHAMT; s++) begin : g_stage
    localparam int SH = 1 << s;
    logic [SH-1:0] hi;
    assign hi         = rotate ? stg[s][SH-1:0] : {SH{fill}};
    assign stg[s+1]   = shamt[s] ? {hi, stg[s][W_DATA-1:SH]} : stg[s];
  end

  assign dout = right_nleft ? stg[W_SHAMT] : res_rev;

endmodule

// File: rtl/hazard3_shift_pipe.sv
// Two-stage shift unit: decode/capture in stage 1, barrel shift into stage 2 result register.
// Latency: 2 cycles from input transfer to out_valid; one op per cycle sustained.
// Backpressure: holds up to 2 ops; in_ready drops when both stages are full and out_ready is low.
module hazard3_shift_pipe
  import hazard3_shift_pipe_pkg::*;
#(
  parameter int W_DATA        = W_DATA_DFLT,
  parameter bit EXTENSION_ZBB = EXTENSION_ZBB_DFLT,
  parameter int W_TAG         = W_TAG_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [W_DATA-1:0] in_rs1,
  input  logic [W_DATA-1:0] in_rs2,
  input  logic [W_TAG-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_DATA-1:0] out_result,
  output logic [W_TAG-1:0]  out_tag,
  output logic              out_illegal
);

  localparam int W_SHAMT = shamt_width(W_DATA);

  logic               s1_valid_q;
  logic [W_DATA-1:0]  s1_rs1_q;
  logic [W_SHAMT-1:0] s1_shamt_q;
  logic [W_TAG-1:0]   s1_tag_q;
  shift_ctrl_t        s1_ctrl_q;
  shift_ctrl_t        ctrl_d;

  logic               s2_valid_q;
  logic [W_DATA-1:0]  s2_result_q;
  logic [W_TAG-1:0]   s2_tag_q;
  logic               s2_illegal_q;
  logic [W_DATA-1:0]  result_d;

  logic               s2_adv;
  logic               s1_adv;
  logic               in_fire;
  logic [W_DATA-1:0]  shift_out;
  logic               unused_rs2_hi;

  // Only the low shamt bits of rs2 matter; the rest are intentionally ignored.
  assign unused_rs2_hi = ^in_rs2[W_DATA-1:W_SHAMT];

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !flush && (!s1_valid_q || s2_adv);
  assign in_fire  = in_valid && in_ready;
  assign ctrl_d   = shift_decode(in_op, EXTENSION_ZBB);
  assign result_d = s1_ctrl_q.illegal ? '0 : shift_out;

  hazard3_shift_barrel #(
    .W_DATA  (W_DATA),
    .W_SHAMT (W_SHAMT)
  ) u_barrel (
    .din         (s1_rs1_q),
    .shamt       (s1_shamt_q),
    .right_nleft (s1_ctrl_q.right_nleft),
    .rotate      (s1_ctrl_q.rotate),
    .arith       (s1_ctrl_q.arith),
    .dout        (shift_out)
  );

  // Stage 1: capture operands and decoded controls on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_rs1_q   <= '0;
      s1_shamt_q <= '0;
      s1_tag_q   <= '0;
      s1_ctrl_q  <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_rs1_q   <= in_rs1;
      s1_shamt_q <= in_rs2[W_SHAMT-1:0];
      s1_tag_q   <= in_tag;
      s1_ctrl_q  <= ctrl_d;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: register the shifter result whenever the output slot can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_result_q  <= '0;
      s2_tag_q     <= '0;
      s2_illegal_q <= 1'b0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q  <= result_d;
        s2_tag_q     <= s1_tag_q;
        s2_illegal_q <= s1_ctrl_q.illegal;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_result  = s2_result_q;
  assign out_tag     = s2_tag_q;
  assign out_illegal = s2_illegal_q;

endmodule
